reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- General-purpose integer register file for the RV32I core: two combinational read ports (rs1/rs2) and one synchronous write port (rd).
- Register 0 is hardwired to zero, per RISC-V.
- Sits between decode (register selects) and the execute/writeback stages (operands out, result in).

Parameters:
- mode, 32, data width of each register in bits.
- reg_number, 32, number of architectural registers, including x0.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, synchronous reset. Active-high despite the name: 1 = reset.
- write, input, 1, write enable for the rd port.
- sel_read_reg1, input, $clog2(reg_number)+1 (6 at default), read port 1 register index.
- sel_read_reg2, input, $clog2(reg_number)+1, read port 2 register index.
- sel_write_reg, input, $clog2(reg_number)+1, write port register index.
- data_in, input, mode, write data (rd value).
- data_out1, output, mode, read data for sel_read_reg1 (rs1).
- data_out2, output, mode, read data for sel_read_reg2 (rs2).

Behaviour:
- Storage: reg_number entries of mode bits each.
  - Entry 0 is not storage; it is a constant 0.
- Reset: sampled on the rising clk edge when reset_n=1.
  - All entries are cleared to 0 on that edge.
  - Reset has priority over a simultaneous write; the write is dropped.
  - Reset may be asserted at any time. The cleared contents are visible on the reads immediately after that edge.
- Write: on a rising clk edge with reset_n=0 and write=1, entry[sel_write_reg] <= data_in.
  - write=0 leaves all entries unchanged, whatever sel_write_reg and data_in are.
- x0: a write with sel_write_reg=0 is ignored. x0 always reads 0.
- Out-of-range index: any index >= reg_number is possible because of the extra select bit.
  - A write to such an index is ignored.
  - A read from such an index returns 0.
- Read: purely combinational, zero latency.
  - data_outN = (selN==0 || selN>=reg_number) ? 0 : entry[selN].
  - Both ports are independent and may select the same register.
- Read-during-write to the same index, default build: the read returns the old value until the clock edge and the new value after it. No bypass.
- After reset and before any write, every register reads 0.
- No X propagation on the outputs after the first reset.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined: when write=1, reset_n=0, sel_write_reg is nonzero and in range, and selN==sel_write_reg, data_outN = data_in combinationally in the same cycle (write-through forwarding).
  - x0 is never bypassed.
- Undefined: no forwarding. Reads reflect only the registered contents, as described in Behaviour.

Test Plan:
- Reset: hold reset_n=1 for 1 cycle, release, then read sel 0..31 on both ports -> all read 0x00000000.
- Basic write: write=1, sel_write_reg=26, data_in=0x00000001, one edge; then sel_read_reg1=26, sel_read_reg2=4 -> data_out1=0x00000001, data_out2=0x00000000.
- Write disabled: write=0, sel_write_reg=2, data_in=0x0000000F, one edge; sel_read_reg1=2 -> data_out1=0x00000000.
- x0 protection: write=1, sel_write_reg=0, data_in=0x0000000A, one edge; sel_read_reg1=0 -> data_out1=0x00000000.
- Reset mid-operation with overlap: x26 holds 0x1; assert reset_n=1 together with write=1, sel_write_reg=5, data_in=0x55 for one edge -> x26 and x5 both read 0.
- Same-index collision: x7 holds 0x11; write 0x22 to x7 while sel_read_reg1=7.
  - Without the macro: 0x11 before the edge, 0x22 after.
  - With REG_FILE_WRITE_BYPASS_EN: 0x22 immediately.
- Out-of-range index, reg_number=32: write 0xDEAD to index 40 -> no register changes; reading index 40 returns 0.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: RV32I integer register file, two combinational read ports and one synchronous write port.
// Ports:
//    clk           - rising-edge clock
//    reset_n       - synchronous reset, active-high despite the name (1 = clear every entry)
//    write         - write enable for the rd port
//    sel_read_reg1 - rs1 index, data returned on data_out1
//    sel_read_reg2 - rs2 index, data returned on data_out2
//    sel_write_reg - rd index
//    data_in       - rd write data
//    data_out1/2   - rs1/rs2 read data; 0 for x0 and for any index >= reg_number
// Optional: define REG_FILE_WRITE_BYPASS_EN to forward data_in to a read port selecting the
// register being written in the same cycle.
module reg_file #(
   parameter int mode       = 32,
   parameter int reg_number = 32,
   localparam int SW        = $clog2(reg_number) + 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            write,
   input  logic [SW-1:0]   sel_read_reg1,
   input  logic [SW-1:0]   sel_read_reg2,
   input  logic [SW-1:0]   sel_write_reg,
   input  logic [mode-1:0] data_in,
   output logic [mode-1:0] data_out1,
   output logic [mode-1:0] data_out2
);
   // x0 has no storage; entries start at 1
   logic [mode-1:0] regs_q [1:reg_number-1];
   logic [mode-1:0] regs_d [1:reg_number-1];
   // Matching against every real entry index makes x0 and out-of-range selects fall through to 0
   function automatic logic [mode-1:0] rd(input logic [SW-1:0] s);
      logic [mode-1:0] v;
      v = '0;
      for (int i = 1; i < reg_number; i++) begin
`ifdef REG_FILE_WRITE_BYPASS_EN
         if (s == SW'(i)) v = (write && !reset_n && sel_write_reg == s) ? data_in : regs_q[i];
`else
         if (s == SW'(i)) v = regs_q[i];
`endif
      end
      return v;
   endfunction
   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i < reg_number; i++)
         if (write && sel_write_reg == SW'(i)) regs_d[i] = data_in;
   end
   always_ff @(posedge clk) begin
      if (reset_n) regs_q <= '{default: '0};
      else regs_q <= regs_d;
   end
   assign data_out1 = rd(sel_read_reg1);
   assign data_out2 = rd(sel_read_reg2);
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file against an array reference model.
module tb_reg_file;
   logic        clk = 0;
   logic        reset_n = 1;
   logic        write = 0;
   logic [5:0]  sel_read_reg1 = 0;
   logic [5:0]  sel_read_reg2 = 0;
   logic [5:0]  sel_write_reg = 0;
   logic [31:0] data_in = 0;
   logic [31:0] data_out1;
   logic [31:0] data_out2;
   logic [31:0] m [32];
   int n_checks = 0;
   int n_fail = 0;

   reg_file dut (
      .clk(clk), .reset_n(reset_n), .write(write),
      .sel_read_reg1(sel_read_reg1), .sel_read_reg2(sel_read_reg2),
      .sel_write_reg(sel_write_reg), .data_in(data_in),
      .data_out1(data_out1), .data_out2(data_out2)
   );

   always #5 clk = ~clk;

   // Architectural view: 32 registers, x0 and indices >= 32 read as zero
   function automatic logic [31:0] model_rd(input logic [5:0] s);
      int k;
      k = int'(s);
      if (k == 0 || k >= 32) return 32'h0;
`ifdef REG_FILE_WRITE_BYPASS_EN
      if (write && !reset_n && s == sel_write_reg) return data_in;
`endif
      return m[k];
   endfunction

   task automatic tick();
      int k;
      @(posedge clk);
      k = int'(sel_write_reg);
      if (reset_n) foreach (m[i]) m[i] = 32'h0;
      else if (write && k != 0 && k < 32) m[k] = data_in;
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1; write = 0;
      tick();
      reset_n = 0;
      for (int i = 0; i < 32; i++) begin
         sel_read_reg1 = 6'(i); sel_read_reg2 = 6'(31 - i); #1;
         n_checks++;
         if (data_out1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 x%0d got %h expected 0", i, data_out1); end
         n_checks++;
         if (data_out2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2 x%0d got %h expected 0", 31 - i, data_out2); end
      end
   endtask

   task automatic test_basic_write();
      write = 1; sel_write_reg = 26; data_in = 32'h1;
      tick();
      write = 0; sel_read_reg1 = 26; sel_read_reg2 = 4; #1;
      n_checks++;
      if (data_out1 !== 32'h1) begin n_fail++; $display("FAIL basic_write x26 got %h expected 00000001", data_out1); end
      n_checks++;
      if (data_out2 !== 32'h0) begin n_fail++; $display("FAIL basic_write x4 got %h expected 0", data_out2); end
   endtask

   task automatic test_write_disabled();
      write = 0; sel_write_reg = 2; data_in = 32'hF;
      tick();
      sel_read_reg1 = 2; #1;
      n_checks++;
      if (data_out1 !== 32'h0) begin n_fail++; $display("FAIL write_disabled x2 got %h expected 0", data_out1); end
   endtask

   task automatic test_x0();
      write = 1; sel_write_reg = 0; data_in = 32'hA; sel_read_reg1 = 0; #1;
      n_checks++;
      if (data_out1 !== 32'h0) begin n_fail++; $display("FAIL x0_during_write got %h expected 0", data_out1); end
      tick();
      write = 0; #1;
      n_checks++;
      if (data_out1 !== 32'h0) begin n_fail++; $display("FAIL x0_after_write got %h expected 0", data_out1); end
   endtask

   task automatic test_reset_overlap();
      sel_read_reg1 = 26; #1;
      n_checks++;
      if (data_out1 !== 32'h1) begin n_fail++; $display("FAIL overlap_pre x26 got %h expected 00000001", data_out1); end
      reset_n = 1; write = 1; sel_write_reg = 5; data_in = 32'h55;
      tick();
      reset_n = 0; write = 0; sel_read_reg2 = 5; #1;
      n_checks++;
      if (data_out1 !== 32'h0) begin n_fail++; $display("FAIL overlap x26 got %h expected 0", data_out1); end
      n_checks++;
      if (data_out2 !== 32'h0) begin n_fail++; $display("FAIL overlap x5 got %h expected 0", data_out2); end
   endtask

   task automatic test_collision();
      write = 1; sel_write_reg = 7; data_in = 32'h11;
      tick();
      data_in = 32'h22; sel_read_reg1 = 7; sel_read_reg2 = 7; #1;
      n_checks++;
`ifdef REG_FILE_WRITE_BYPASS_EN
      if (data_out1 !== 32'h22) begin n_fail++; $display("FAIL collision_before got %h expected 00000022", data_out1); end
`else
      if (data_out1 !== 32'h11) begin n_fail++; $display("FAIL collision_before got %h expected 00000011", data_out1); end
`endif
      tick();
      write = 0; #1;
      n_checks++;
      if (data_out1 !== 32'h22) begin n_fail++; $display("FAIL collision_after got %h expected 00000022", data_out1); end
      n_checks++;
      if (data_out2 !== 32'h22) begin n_fail++; $display("FAIL collision_after_rd2 got %h expected 00000022", data_out2); end
   endtask

   task automatic test_out_of_range();
      write = 1; sel_write_reg = 40; data_in = 32'hDEAD; sel_read_reg2 = 40; #1;
      n_checks++;
      if (data_out2 !== 32'h0) begin n_fail++; $display("FAIL oor_during_write got %h expected 0", data_out2); end
      tick();
      write = 0;
      for (int i = 0; i < 32; i++) begin
         sel_read_reg1 = 6'(i); #1;
         n_checks++;
         if (data_out1 !== model_rd(6'(i))) begin n_fail++; $display("FAIL oor_scan x%0d got %h expected %h", i, data_out1, model_rd(6'(i))); end
         if (int'(data_out1) == 32'hDEAD && i != 7) $display("FAIL oor_leak x%0d got %h expected %h", i, data_out1, model_rd(6'(i)));
      end
      n_checks++;
      if (data_out2 !== 32'h0) begin n_fail++; $display("FAIL oor_read40 got %h expected 0", data_out2); end
   endtask

   task automatic test_random();
      logic [31:0] e1, e2;
      for (int n = 0; n < 400; n++) begin
         reset_n = ($urandom_range(0, 39) == 0);
         write = $urandom_range(0, 3) != 0;
         sel_write_reg = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 0) sel_write_reg = 6'($urandom_range(0, 31));
         data_in = $urandom;
         sel_read_reg1 = ($urandom_range(0, 3) == 0) ? sel_write_reg : 6'($urandom_range(0, 63));
         sel_read_reg2 = 6'($urandom_range(0, 33));
         #1;
         e1 = model_rd(sel_read_reg1); e2 = model_rd(sel_read_reg2);
         n_checks++;
         if (data_out1 !== e1) begin n_fail++; $display("FAIL random_rd1 n=%0d sel=%0d got %h expected %h", n, sel_read_reg1, data_out1, e1); end
         n_checks++;
         if (data_out2 !== e2) begin n_fail++; $display("FAIL random_rd2 n=%0d sel=%0d got %h expected %h", n, sel_read_reg2, data_out2, e2); end
         tick();
      end
      reset_n = 0; write = 0;
      for (int i = 0; i < 32; i++) begin
         sel_read_reg1 = 6'(i); #1;
         n_checks++;
         if (data_out1 !== m[i]) begin n_fail++; $display("FAIL random_final x%0d got %h expected %h", i, data_out1, (i == 0) ? 32'h0 : m[i]); end
      end
   endtask

   initial begin
      foreach (m[i]) m[i] = 32'h0;
      test_reset();
      test_basic_write();
      test_write_disabled();
      test_x0();
      test_reset_overlap();
      test_collision();
      test_out_of_range();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
